// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder.
// Accepts byte-addressed fetch requests from the PC side and returns the
// addressed word from a word-organised store after a fixed number of wait
// states. Each response is held until the fetch stage takes it. A flush
// cancels any outstanding work. A load port fills the store independently
// of the fetch handshake.
module instr_mem_responder #(
  parameter int                  BitWidth    = 32,
  parameter int                  InstrWidth  = 32,
  parameter int                  Depth       = 256,
  parameter int                  WaitStates  = 1,
  parameter logic [BitWidth-1:0] BaseAddress = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [BitWidth-1:0]        req_addr,
  input  logic                       flush,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [InstrWidth-1:0]      instr,
  output logic                       fault,
  input  logic                       load_en,
  input  logic [$clog2(Depth)-1:0]   load_index,
  input  logic [InstrWidth-1:0]      load_data
);

  localparam int Stride = InstrWidth >> 3;
  localparam int IdxW   = $clog2(Depth);
  // The wait counter starts one below the wait-state count so that it
  // reaches zero on the last wait cycle.
  localparam logic [3:0] WaitInit = (WaitStates == 0) ? 4'd0 : 4'(WaitStates - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                  state_q;
  logic [3:0]              wait_cnt_q;
  logic [BitWidth-1:0]     addr_q;
  logic                    resp_valid_q;
  logic [InstrWidth-1:0]   instr_q;
  logic                    fault_q;
  logic [InstrWidth-1:0]   store_q [Depth];

  logic                    accept;
  logic [BitWidth-1:0]     cap_addr;
  logic                    cap_fault_d;
  logic [InstrWidth-1:0]   cap_instr_d;

  // Faults when the address lies below the base, is not word aligned,
  // or points past the last word. The extra borrow bit catches addresses
  // below the base without relying on the subtraction wrapping.
  function automatic logic addr_faults(input logic [BitWidth-1:0] a);
    logic [BitWidth:0]   diff;
    logic [BitWidth-1:0] off;
    diff = {1'b0, a} - {1'b0, BaseAddress};
    off  = diff[BitWidth-1:0];
    return diff[BitWidth]
        || ((off % BitWidth'(Stride)) != '0)
        || ((off / BitWidth'(Stride)) >= BitWidth'(Depth));
  endfunction

  // Word index of a byte address; only meaningful when the address does
  // not fault.
  function automatic logic [IdxW-1:0] word_index(input logic [BitWidth-1:0] a);
    return IdxW'((a - BaseAddress) / BitWidth'(Stride));
  endfunction

  // Ready when idle, or when the held response is being consumed this
  // cycle; never during reset or a redirect.
  always_comb begin
    req_ready = reset && !flush
             && ((state_q == IDLE) || ((state_q == RESP) && resp_ready));
  end

  assign accept = req_valid && req_ready;

  // Response word for the edge that enters RESP. With no wait states the
  // request address is used directly; otherwise the latched one. The store
  // is read asynchronously, so a load on the same edge returns the old word.
  always_comb begin
    cap_addr    = (state_q == WAIT) ? addr_q : req_addr;
    cap_fault_d = addr_faults(cap_addr);
    cap_instr_d = cap_fault_d ? '0 : store_q[word_index(cap_addr)];
  end

  // Store fill port; independent of the fetch state, blocked only in reset.
  always_ff @(posedge clock) begin
    if (reset && load_en) begin
      store_q[load_index] <= load_data;
    end
  end

  // Fetch FSM with registered response outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      resp_valid_q <= 1'b0;
      instr_q      <= '0;
      fault_q      <= 1'b0;
    end else if (flush) begin
      // Redirect: drop whatever is in flight or being presented.
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      resp_valid_q <= 1'b0;
    end else if (accept) begin
      // New request, either from IDLE or back-to-back out of RESP.
      addr_q <= req_addr;
      if (WaitStates == 0) begin
        state_q      <= RESP;
        resp_valid_q <= 1'b1;
        instr_q      <= cap_instr_d;
        fault_q      <= cap_fault_d;
      end else begin
        state_q      <= WAIT;
        wait_cnt_q   <= WaitInit;
        resp_valid_q <= 1'b0;
      end
    end else begin
      case (state_q)
        WAIT: begin
          if (wait_cnt_q == '0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            instr_q      <= cap_instr_d;
            fault_q      <= cap_fault_d;
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
          end
        end
        IDLE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign instr      = instr_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: three instances (0, 1 and 3 wait states)
// share one stimulus stream and are compared against a transaction-level
// reference model.
module tb_instr_mem_responder;

  localparam int     NI    = 3;
  localparam int     DEPTH = 256;
  localparam longint BASE  = 0;

  logic clock = 1'b0;
  logic reset, req_valid, flush, resp_ready, load_en;
  logic [31:0] req_addr, load_data;
  logic [7:0]  load_index;

  logic [NI-1:0]       rq_rdy, rsp_v, flt;
  logic [NI-1:0][31:0] ins;

  int checks = 0;
  int errors = 0;

  // Reference model: per instance, an outstanding request with the number
  // of edges left until its answer, and the answer currently presented.
  bit          m_pend  [NI];
  int          m_rem   [NI];
  logic [31:0] m_addr  [NI];
  bit          m_rv    [NI];
  logic [31:0] m_instr [NI];
  bit          m_flt   [NI];
  logic [31:0] mem     [DEPTH];

  always #5 clock = ~clock;

  instr_mem_responder #(.WaitStates(0)) u_ws0 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rq_rdy[0]),
    .req_addr(req_addr), .flush(flush), .resp_valid(rsp_v[0]), .resp_ready(resp_ready),
    .instr(ins[0]), .fault(flt[0]), .load_en(load_en), .load_index(load_index),
    .load_data(load_data));

  instr_mem_responder #(.WaitStates(1)) u_ws1 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rq_rdy[1]),
    .req_addr(req_addr), .flush(flush), .resp_valid(rsp_v[1]), .resp_ready(resp_ready),
    .instr(ins[1]), .fault(flt[1]), .load_en(load_en), .load_index(load_index),
    .load_data(load_data));

  instr_mem_responder #(.WaitStates(3)) u_ws3 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rq_rdy[2]),
    .req_addr(req_addr), .flush(flush), .resp_valid(rsp_v[2]), .resp_ready(resp_ready),
    .instr(ins[2]), .fault(flt[2]), .load_en(load_en), .load_index(load_index),
    .load_data(load_data));

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  function automatic bit addr_fault(input logic [31:0] a);
    longint off;
    off = longint'(a) - BASE;
    return (off < 0) || ((off % 4) != 0) || ((off / 4) >= DEPTH);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((longint'(a) - BASE) / 4);
  endfunction

  function automatic bit exp_ready(input int k);
    bit free;
    free = !m_pend[k] && !m_rv[k];
    return reset && !flush && (free || (m_rv[k] && resp_ready));
  endfunction

  task automatic deliver(input int k, input logic [31:0] a);
    m_rv[k]    = 1'b1;
    m_flt[k]   = addr_fault(a);
    m_instr[k] = m_flt[k] ? 32'h0 : mem[word_of(a)];
  endtask

  // Advance the model by one rising edge using the inputs present now.
  task automatic model_edge();
    for (int k = 0; k < NI; k++) begin
      if (!reset) begin
        m_pend[k] = 1'b0; m_rv[k] = 1'b0; m_instr[k] = 32'h0; m_flt[k] = 1'b0;
      end else if (flush) begin
        m_pend[k] = 1'b0; m_rv[k] = 1'b0;
      end else begin
        bit acc;
        acc = req_valid && exp_ready(k);
        if (m_rv[k] && resp_ready) m_rv[k] = 1'b0;
        if (m_pend[k]) begin
          m_rem[k] = m_rem[k] - 1;
          if (m_rem[k] == 0) begin
            m_pend[k] = 1'b0;
            deliver(k, m_addr[k]);
          end
        end
        if (acc) begin
          if (ws_of(k) == 0) deliver(k, req_addr);
          else begin
            m_pend[k] = 1'b1; m_rem[k] = ws_of(k); m_addr[k] = req_addr;
          end
        end
      end
    end
    if (reset && load_en) mem[load_index] = load_data;
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic drain();
    req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b1; load_en = 1'b0;
    repeat (6) step();
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b1; req_addr = 32'h0; flush = 1'b0;
    resp_ready = 1'b0; load_en = 1'b0; load_index = 8'h0; load_data = 32'h0;
    step(); step();
    #1;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (rsp_v[k] !== 1'b0 || ins[k] !== 32'h0 || flt[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_out[%0d]: rv=%b instr=%h fault=%b, expected 0/0/0", k, rsp_v[k], ins[k], flt[k]);
      end
      checks++;
      if (rq_rdy[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_ready[%0d]: got %b expected 0", k, rq_rdy[k]);
      end
    end
    req_valid = 1'b0; reset = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (rq_rdy[k] !== 1'b1) begin
        errors++;
        $display("FAIL idle_ready[%0d]: got %b expected 1", k, rq_rdy[k]);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      load_en = 1'b1; load_index = 8'(i);
      load_data = (i < 4) ? 32'(32'h11111111 * (i + 1)) : $urandom;
      step();
    end
    load_en = 1'b0;
  endtask

  task automatic test_basic();
    resp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h4;
    #1;
    checks++;
    if (rq_rdy[1] !== 1'b1) begin
      errors++; $display("FAIL basic_ready: got %b expected 1", rq_rdy[1]);
    end
    step();
    req_valid = 1'b0;
    checks++;
    if (rsp_v[1] !== 1'b0) begin
      errors++; $display("FAIL basic_wait: rv=%b expected 0", rsp_v[1]);
    end
    checks++;
    if (rsp_v[0] !== 1'b1 || ins[0] !== 32'h22222222 || flt[0] !== 1'b0) begin
      errors++; $display("FAIL basic_ws0: rv=%b instr=%h fault=%b, expected 1/22222222/0", rsp_v[0], ins[0], flt[0]);
    end
    step();
    checks++;
    if (rsp_v[1] !== 1'b1 || ins[1] !== 32'h22222222 || flt[1] !== 1'b0) begin
      errors++; $display("FAIL basic_resp: rv=%b instr=%h fault=%b, expected 1/22222222/0", rsp_v[1], ins[1], flt[1]);
    end
    step();
    #1;
    checks++;
    if (rsp_v[1] !== 1'b0 || rq_rdy[1] !== 1'b1) begin
      errors++; $display("FAIL basic_idle: rv=%b ready=%b, expected 0/1", rsp_v[1], rq_rdy[1]);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] exp_w;
      exp_w = 32'(32'h11111111 * (i + 1));
      req_valid = 1'b1; req_addr = 32'(i * 4);
      #1;
      checks++;
      if (rq_rdy[0] !== 1'b1) begin
        errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, rq_rdy[0]);
      end
      step();
      checks++;
      if (rsp_v[0] !== 1'b1 || ins[0] !== exp_w) begin
        errors++; $display("FAIL b2b_resp[%0d]: rv=%b instr=%h, expected 1/%h", i, rsp_v[0], ins[0], exp_w);
      end
    end
    req_valid = 1'b0;
    step();
    checks++;
    if (rsp_v[0] !== 1'b0) begin
      errors++; $display("FAIL b2b_end: rv=%b expected 0", rsp_v[0]);
    end
    drain();
  endtask

  task automatic test_fault();
    logic [31:0] fa [4];
    bit          ff [4];
    logic [31:0] fi [4];
    fa = '{32'h6, 32'h400, 32'h3FC, 32'h3FD};
    ff = '{1'b1, 1'b1, 1'b0, 1'b1};
    fi = '{32'h0, 32'h0, mem[255], 32'h0};
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bit got;
      req_valid = 1'b1; req_addr = fa[i];
      step();
      req_valid = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        if (rsp_v[1] === 1'b1) got = 1'b1;
        else step();
      end
      checks++;
      if (!got) begin
        errors++; $display("FAIL fault_timeout[%h]: no response within 8 cycles, expected one", fa[i]);
      end else if (flt[1] !== ff[i] || ins[1] !== fi[i]) begin
        errors++; $display("FAIL fault_addr[%h]: fault=%b instr=%h, expected %b/%h", fa[i], flt[1], ins[1], ff[i], fi[i]);
      end
      drain();
    end
  endtask

  task automatic test_stall();
    resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h8;
    step();
    req_valid = 1'b0;
    repeat (4) step();
    req_valid = 1'b1; req_addr = 32'hC;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (rq_rdy !== 3'b000) begin
        errors++; $display("FAIL stall_ready[%0d]: got %b expected 000", i, rq_rdy);
      end
      step();
      checks++;
      if (rsp_v !== 3'b111 || ins[0] !== 32'h33333333 || ins[1] !== 32'h33333333
          || ins[2] !== 32'h33333333 || flt !== 3'b000) begin
        errors++; $display("FAIL stall_hold[%0d]: rv=%b instr=%h/%h/%h fault=%b, expected 111/33333333 x3/000",
                           i, rsp_v, ins[0], ins[1], ins[2], flt);
      end
    end
    resp_ready = 1'b1;
    #1;
    checks++;
    if (rq_rdy !== 3'b111) begin
      errors++; $display("FAIL stall_release_ready: got %b expected 111", rq_rdy);
    end
    step();
    req_valid = 1'b0;
    checks++;
    if (rsp_v !== 3'b001 || ins[0] !== 32'h44444444) begin
      errors++; $display("FAIL stall_next: rv=%b instr0=%h, expected 001/44444444", rsp_v, ins[0]);
    end
    drain();
  endtask

  task automatic test_flush();
    resp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h4;
    step();
    req_valid = 1'b0;
    for (int j = 0; j < 2; j++) begin
      checks++;
      if (rsp_v[2] !== 1'b0) begin
        errors++; $display("FAIL flush_pre[%0d]: rv=%b expected 0", j, rsp_v[2]);
      end
      if (j == 0) step();
    end
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h8;
    #1;
    checks++;
    if (rq_rdy !== 3'b000) begin
      errors++; $display("FAIL flush_ready: got %b expected 000", rq_rdy);
    end
    step();
    flush = 1'b0;
    checks++;
    if (rsp_v !== 3'b000) begin
      errors++; $display("FAIL flush_clear: rv=%b expected 000", rsp_v);
    end
    req_addr = 32'hC;
    #1;
    checks++;
    if (rq_rdy[2] !== 1'b1) begin
      errors++; $display("FAIL flush_new_ready: got %b expected 1", rq_rdy[2]);
    end
    step();
    req_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (rsp_v[2] !== 1'b0) begin
        errors++; $display("FAIL flush_new_early[%0d]: rv=%b expected 0", j, rsp_v[2]);
      end
      step();
    end
    checks++;
    if (rsp_v[2] !== 1'b1 || ins[2] !== 32'h44444444 || flt[2] !== 1'b0) begin
      errors++; $display("FAIL flush_new_resp: rv=%b instr=%h fault=%b, expected 1/44444444/0", rsp_v[2], ins[2], flt[2]);
    end
    step();
    checks++;
    if (rsp_v[2] !== 1'b0) begin
      errors++; $display("FAIL flush_after: rv=%b expected 0", rsp_v[2]);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    resp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
    step();
    req_valid = 1'b0;
    step();
    reset = 1'b0; req_valid = 1'b1;
    load_en = 1'b1; load_index = 8'h0; load_data = 32'hDEADBEEF;
    step();
    #1;
    checks++;
    if (rsp_v !== 3'b000 || rq_rdy !== 3'b000) begin
      errors++; $display("FAIL midreset: rv=%b ready=%b, expected 000/000", rsp_v, rq_rdy);
    end
    reset = 1'b1; load_en = 1'b0; req_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      step();
      checks++;
      if (rsp_v !== 3'b000) begin
        errors++; $display("FAIL midreset_dropped[%0d]: rv=%b expected 000", j, rsp_v);
      end
    end
    req_valid = 1'b1; req_addr = 32'h0;
    step();
    req_valid = 1'b0;
    step();
    checks++;
    if (rsp_v[1] !== 1'b1 || ins[1] !== 32'h11111111 || flt[1] !== 1'b0) begin
      errors++; $display("FAIL midreset_store: rv=%b instr=%h fault=%b, expected 1/11111111/0", rsp_v[1], ins[1], flt[1]);
    end
    drain();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      reset      = ($urandom_range(0, 59) != 0);
      flush      = ($urandom_range(0, 11) == 0);
      req_valid  = 1'($urandom_range(0, 1));
      resp_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       req_addr = $urandom;
        1:       req_addr = 32'h3F8 + 32'($urandom_range(0, 15));
        default: req_addr = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      endcase
      load_en    = ($urandom_range(0, 3) == 0);
      load_index = 8'($urandom_range(0, 255));
      load_data  = $urandom;
      #1;
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (rq_rdy[k] !== exp_ready(k)) begin
          errors++; $display("FAIL rand_ready[%0d] n=%0d: got %b expected %b", k, n, rq_rdy[k], exp_ready(k));
        end
      end
      step();
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (rsp_v[k] !== m_rv[k]) begin
          errors++; $display("FAIL rand_valid[%0d] n=%0d: got %b expected %b", k, n, rsp_v[k], m_rv[k]);
        end else if (m_rv[k]) begin
          checks++;
          if (ins[k] !== m_instr[k] || flt[k] !== m_flt[k]) begin
            errors++; $display("FAIL rand_data[%0d] n=%0d: instr=%h fault=%b expected %h/%b",
                               k, n, ins[k], flt[k], m_instr[k], m_flt[k]);
          end
        end
      end
    end
    reset = 1'b1;
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_fault();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
